// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU and LSU result channels in, register file write port
// and retire counter out. "master" drives results, "slave" is the arbiter.
interface wb_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic                  alu_wen;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_rdata;
  logic [1:0]            lsu_addr_lo;
  logic [1:0]            lsu_size;
  logic                  lsu_unsigned;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [CNT_WIDTH-1:0]  retire_cnt;

  modport master (
    output alu_valid, alu_wen, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_rdata, lsu_addr_lo, lsu_size, lsu_unsigned,
    input  alu_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata, retire_cnt
  );

  modport slave (
    input  alu_valid, alu_wen, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_rdata, lsu_addr_lo, lsu_size, lsu_unsigned,
    output alu_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata, retire_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback stage: round-robin merge of ALU and load results into one registered
// register-file write per cycle, with load alignment/extension and a retire counter.
module wb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  typedef enum logic {PrioLsu, PrioAlu} prio_e;

  prio_e                 prio_q, prio_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [CNT_WIDTH-1:0]  retire_cnt_q, retire_cnt_d;

  logic                  grant_lsu;
  logic                  grant_alu;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  ld_sign;
  logic [DATA_WIDTH-1:0] ld_data;

  // Grant depends only on valids and the pointer, never on ready.
  always_comb begin
    grant_lsu = bus.lsu_valid && (!bus.alu_valid || (prio_q == PrioLsu));
    grant_alu = bus.alu_valid && !grant_lsu;
    prio_d    = prio_q;
    if (bus.alu_valid && bus.lsu_valid) begin
      prio_d = grant_lsu ? PrioAlu : PrioLsu;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.lsu_ready = grant_lsu;

  always_comb begin
    ld_byte = bus.lsu_rdata[{bus.lsu_addr_lo, 3'b000} +: 8];
    ld_half = bus.lsu_rdata[{bus.lsu_addr_lo[1], 4'b0000} +: 16];
    ld_sign = 1'b0;
    ld_data = bus.lsu_rdata;
    case (bus.lsu_size)
      2'd0: begin
        ld_sign = !bus.lsu_unsigned && ld_byte[7];
        ld_data = {{(DATA_WIDTH-8){ld_sign}}, ld_byte};
      end
      2'd1: begin
        ld_sign = !bus.lsu_unsigned && ld_half[15];
        ld_data = {{(DATA_WIDTH-16){ld_sign}}, ld_half};
      end
      default: ld_data = bus.lsu_rdata;
    endcase
  end

  // Address/data hold when idle; only the enable drops.
  always_comb begin
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    retire_cnt_d = retire_cnt_q;
    if (grant_lsu) begin
      rf_wen_d   = (bus.lsu_rd != '0);
      rf_waddr_d = bus.lsu_rd;
      rf_wdata_d = ld_data;
    end else if (grant_alu) begin
      rf_wen_d   = bus.alu_wen && (bus.alu_rd != '0);
      rf_waddr_d = bus.alu_rd;
      rf_wdata_d = bus.alu_data;
    end
    if (grant_lsu || grant_alu) begin
      retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= PrioLsu;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      prio_q       <= prio_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.rf_wen     = rf_wen_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a default instance plus a 4-bit-counter instance
// for the wrap and asynchronous reset scenario.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(32)) bus ();
  wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(4))  bus4 ();

  wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  task automatic clear_inputs();
    bus.alu_valid = 0; bus.alu_wen = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_rdata = '0;
    bus.lsu_addr_lo = '0; bus.lsu_size = '0; bus.lsu_unsigned = 0;
    bus4.alu_valid = 0; bus4.alu_wen = 0; bus4.alu_rd = '0; bus4.alu_data = '0;
    bus4.lsu_valid = 0; bus4.lsu_rd = '0; bus4.lsu_rdata = '0;
    bus4.lsu_addr_lo = '0; bus4.lsu_size = '0; bus4.lsu_unsigned = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.rf_wen !== 1'b0) begin
      n_fail++; $display("FAIL reset_wen: got %b expected 0", bus.rf_wen);
    end
    n_checks++;
    if (bus.rf_waddr !== 5'd0) begin
      n_fail++; $display("FAIL reset_waddr: got %h expected 00", bus.rf_waddr);
    end
    n_checks++;
    if (bus.rf_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_wdata: got %h expected 00000000", bus.rf_wdata);
    end
    n_checks++;
    if (bus.retire_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.retire_cnt);
    end
    n_checks++;
    if ({bus.alu_ready, bus.lsu_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 00", {bus.alu_ready, bus.lsu_ready});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_alu();
    do_reset();
    bus.alu_valid = 1; bus.alu_wen = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    #1;
    n_checks++;
    if ({bus.alu_ready, bus.lsu_ready} !== 2'b10) begin
      n_fail++; $display("FAIL alu_ready: got %b expected 10", {bus.alu_ready, bus.lsu_ready});
    end
    @(negedge clk);
    bus.alu_valid = 0;
    n_checks++;
    if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
      n_fail++;
      $display("FAIL alu_write: got wen=%b addr=%0d data=%h expected 1/5/00001234",
               bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
    end
    n_checks++;
    if (bus.retire_cnt !== 32'd1) begin
      n_fail++; $display("FAIL alu_cnt: got %0d expected 1", bus.retire_cnt);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd5, 32'h1234}) begin
      n_fail++;
      $display("FAIL idle_hold: got wen=%b addr=%0d data=%h expected 0/5/00001234",
               bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_rd   [4] = '{5'd2, 5'd1, 5'd3, 5'd4};
    logic [31:0] exp_data [4] = '{32'hB0, 32'hA0, 32'hB1, 32'hA1};
    do_reset();
    bus.alu_valid = 1; bus.alu_wen = 1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA0;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd2; bus.lsu_rdata = 32'hB0; bus.lsu_size = 2'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({bus.alu_ready, bus.lsu_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got alu/lsu ready=%b expected %b", i,
                 {bus.alu_ready, bus.lsu_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b1, exp_rd[i], exp_data[i]}) begin
        n_fail++;
        $display("FAIL rr_write%0d: got wen=%b addr=%0d data=%h expected 1/%0d/%h", i,
                 bus.rf_wen, bus.rf_waddr, bus.rf_wdata, exp_rd[i], exp_data[i]);
      end
      case (i)
        0: begin bus.lsu_rd = 5'd3; bus.lsu_rdata = 32'hB1; end
        1: begin bus.alu_rd = 5'd4; bus.alu_data = 32'hA1; end
        2: begin bus.lsu_rd = 5'd6; bus.lsu_rdata = 32'hB2; end
        default: begin bus.alu_valid = 0; bus.lsu_valid = 0; end
      endcase
    end
    n_checks++;
    if (bus.retire_cnt !== 32'd4) begin
      n_fail++; $display("FAIL rr_cnt: got %0d expected 4", bus.retire_cnt);
    end
  endtask

  task automatic test_load_format();
    ld_vec_t vecs [10] = '{
      '{2'd0, 1'b0, 2'd3, 32'hFFFFFF80},
      '{2'd0, 1'b1, 2'd1, 32'h0000007F},
      '{2'd1, 1'b0, 2'd2, 32'hFFFF80FF},
      '{2'd2, 1'b0, 2'd0, 32'h80FF7F01},
      '{2'd0, 1'b0, 2'd2, 32'hFFFFFFFF},
      '{2'd1, 1'b1, 2'd3, 32'h000080FF},
      '{2'd1, 1'b0, 2'd1, 32'h00007F01},
      '{2'd3, 1'b1, 2'd2, 32'h80FF7F01},
      '{2'd0, 1'b0, 2'd1, 32'h0000007F},
      '{2'd1, 1'b1, 2'd0, 32'h00007F01}
    };
    do_reset();
    bus.lsu_valid = 1; bus.lsu_rd = 5'd9; bus.lsu_rdata = 32'h80FF7F01;
    for (int i = 0; i < 10; i++) begin
      bus.lsu_size = vecs[i].size;
      bus.lsu_unsigned = vecs[i].uns;
      bus.lsu_addr_lo = vecs[i].off;
      @(negedge clk);
      n_checks++;
      if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd9, vecs[i].exp}) begin
        n_fail++;
        $display("FAIL load_fmt%0d: got wen=%b addr=%0d data=%h expected 1/9/%h", i,
                 bus.rf_wen, bus.rf_waddr, bus.rf_wdata, vecs[i].exp);
      end
    end
    bus.lsu_valid = 0;
  endtask

  task automatic test_no_write();
    do_reset();
    bus.alu_valid = 1; bus.alu_wen = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD;
    @(negedge clk);
    n_checks++;
    if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd0, 32'hDEAD}) begin
      n_fail++;
      $display("FAIL rd0_alu: got wen=%b addr=%0d data=%h expected 0/0/0000dead",
               bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
    end
    bus.alu_wen = 0; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    @(negedge clk);
    bus.alu_valid = 0;
    n_checks++;
    if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd7, 32'h77}) begin
      n_fail++;
      $display("FAIL wen0_alu: got wen=%b addr=%0d data=%h expected 0/7/00000077",
               bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
    end
    n_checks++;
    if (bus.retire_cnt !== 32'd2) begin
      n_fail++; $display("FAIL no_write_cnt: got %0d expected 2", bus.retire_cnt);
    end
    bus.lsu_valid = 1; bus.lsu_rd = 5'd0; bus.lsu_rdata = 32'h55; bus.lsu_size = 2'd2;
    @(negedge clk);
    bus.lsu_valid = 0;
    n_checks++;
    if ({bus.rf_wen, bus.rf_wdata, bus.retire_cnt} !== {1'b0, 32'h55, 32'd3}) begin
      n_fail++;
      $display("FAIL rd0_lsu: got wen=%b data=%h cnt=%0d expected 0/00000055/3",
               bus.rf_wen, bus.rf_wdata, bus.retire_cnt);
    end
  endtask

  task automatic test_wrap_async_reset();
    do_reset();
    bus4.alu_valid = 1; bus4.alu_wen = 1;
    for (int i = 0; i < 16; i++) begin
      bus4.alu_rd = 5'(i + 1);
      bus4.alu_data = 32'(i);
      @(negedge clk);
      if (i == 14) begin
        n_checks++;
        if (bus4.retire_cnt !== 4'hF) begin
          n_fail++; $display("FAIL cnt_15: got %0d expected 15", bus4.retire_cnt);
        end
      end
    end
    n_checks++;
    if (bus4.retire_cnt !== 4'h0) begin
      n_fail++; $display("FAIL cnt_wrap: got %0d expected 0", bus4.retire_cnt);
    end
    @(negedge clk);
    n_checks++;
    if ({bus4.rf_wen, bus4.retire_cnt} !== {1'b1, 4'h1}) begin
      n_fail++;
      $display("FAIL pre_reset: got wen=%b cnt=%0d expected 1/1", bus4.rf_wen, bus4.retire_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus4.rf_wen, bus4.retire_cnt, bus4.rf_waddr} !== {1'b0, 4'h0, 5'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got wen=%b cnt=%0d addr=%0d expected 0/0/0",
               bus4.rf_wen, bus4.retire_cnt, bus4.rf_waddr);
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_alu();
    test_back_to_back();
    test_load_format();
    test_no_write();
    test_wrap_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
